// File: rtl/board_mem_writer_pkg.sv
// Shared types for the board-driven RAM writer.
package board_mem_writer_pkg;

   typedef logic [31:0] word_t;
   typedef logic [15:0] half_t;

   typedef enum logic {IDLE, WRITE} mw_state_t;

   localparam int unsigned WORD_ALIGN_BITS = 2;

endpackage

// File: rtl/board_mem_writer_if.sv
// System-side RAM write path driven by the board writer; halt comes back from the CPU.
interface board_mem_writer_if;
   import board_mem_writer_pkg::*;

   logic  halt;
   logic  tb_ctrl;
   logic  wen;
   word_t addr;
   word_t store;

   modport master (input halt, output tb_ctrl, output wen, output addr, output store);
   modport slave  (output halt, input tb_ctrl, input wen, input addr, input store);

endinterface

// File: rtl/board_mem_writer_key.sv
// Push-button conditioning: 2-flop sync, stable-level debounce, falling-edge press pulse.
module key_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic CLK,
   input  logic RST,
   input  logic key_n,
   output logic press
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          s1_q;
   logic          s2_q;
   logic          level_q;
   logic          prev_q;
   logic [CW-1:0] cnt_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         s1_q    <= 1'b1;
         s2_q    <= 1'b1;
         level_q <= 1'b1;
         prev_q  <= 1'b1;
         cnt_q   <= '0;
         press   <= 1'b0;
      end else begin
         s1_q   <= key_n;
         s2_q   <= s1_q;
         prev_q <= level_q;
         press  <= prev_q & ~level_q;
         // Count only while the synchronized level disagrees with the accepted one.
         if (s2_q == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            level_q <= s2_q;
            cnt_q   <= '0;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

endmodule

// File: rtl/board_mem_writer.sv
// Assembles a 32-bit word from switches and writes it to RAM once per commit press while halted.
module board_mem_writer
   import board_mem_writer_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned WRITE_CYCLES    = 2
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [2:0]                key_n,
   input  logic [15:0]               sw,
   board_mem_writer_if.master        mem,
   output logic                      busy,
   output logic                      done,
   output logic                      err,
   output logic [15:0]               wr_count
);

   localparam int unsigned CW = (WRITE_CYCLES > 1) ? $clog2(WRITE_CYCLES) : 1;

   logic [2:0]    press;
   mw_state_t     state_q;
   logic [CW-1:0] cyc_q;
   half_t         lo_q;
   half_t         hi_q;
   word_t         addr_q;
   word_t         store_q;
   logic          wen_q;
   logic          done_q;
   logic          err_q;
   logic [15:0]   wr_cnt_q;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key0 (.CLK(CLK), .RST(RST), .key_n(key_n[0]), .press(press[0]));
   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key1 (.CLK(CLK), .RST(RST), .key_n(key_n[1]), .press(press[1]));
   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key2 (.CLK(CLK), .RST(RST), .key_n(key_n[2]), .press(press[2]));

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= IDLE;
         cyc_q    <= '0;
         lo_q     <= '0;
         hi_q     <= '0;
         addr_q   <= '0;
         store_q  <= '0;
         wen_q    <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         wr_cnt_q <= '0;
      end else begin
         done_q <= 1'b0;
         if (press[0]) lo_q <= sw;
         if (press[1]) hi_q <= sw;
         // A commit in the same cycle as a half latch snapshots the old halves.
         case (state_q)
            IDLE: begin
               if (press[2]) begin
                  if (mem.halt && (sw[WORD_ALIGN_BITS-1:0] == '0)) begin
                     state_q <= WRITE;
                     addr_q  <= {16'h0000, sw};
                     store_q <= {hi_q, lo_q};
                     cyc_q   <= CW'(WRITE_CYCLES - 1);
                     wen_q   <= 1'b1;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            WRITE: begin
               if (cyc_q == '0) begin
                  state_q  <= IDLE;
                  wen_q    <= 1'b0;
                  done_q   <= 1'b1;
                  wr_cnt_q <= wr_cnt_q + 16'd1;
               end else begin
                  cyc_q <= cyc_q - CW'(1);
               end
            end
         endcase
      end
   end

   assign mem.tb_ctrl = wen_q;
   assign mem.wen     = wen_q;
   assign mem.addr    = addr_q;
   assign mem.store   = store_q;
   assign busy        = wen_q;
   assign done        = done_q;
   assign err         = err_q;
   assign wr_count    = wr_cnt_q;

endmodule

// File: tb/tb_board_mem_writer.sv
// Directed bench: table of latch/commit vectors plus hand sequences for bounce, reset, wrap and overlap.
module tb_board_mem_writer;
   import board_mem_writer_pkg::*;

   logic        clk;
   logic        rst;
   logic [2:0]  key_a, key_b;
   logic [15:0] sw_a, sw_b;
   logic        busy_a, done_a, err_a, busy_b, done_b, err_b;
   logic [15:0] cnt_a, cnt_b;

   board_mem_writer_if bus_a ();
   board_mem_writer_if bus_b ();

   board_mem_writer #(.DEBOUNCE_CYCLES(4), .WRITE_CYCLES(2)) dut_a (
      .CLK(clk), .RST(rst), .key_n(key_a), .sw(sw_a), .mem(bus_a),
      .busy(busy_a), .done(done_a), .err(err_a), .wr_count(cnt_a));

   board_mem_writer #(.DEBOUNCE_CYCLES(1), .WRITE_CYCLES(4)) dut_b (
      .CLK(clk), .RST(rst), .key_n(key_b), .sw(sw_b), .mem(bus_b),
      .busy(busy_b), .done(done_b), .err(err_b), .wr_count(cnt_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitors tally wen cycles, done pulses and bad bus values against the expected snapshot.
   int    wen_a_n = 0, done_a_n = 0, bad_a_n = 0;
   int    wen_b_n = 0, done_b_n = 0, bad_b_n = 0;
   word_t exp_addr_a, exp_store_a, exp_addr_b, exp_store_b;

   always @(negedge clk) begin
      if (bus_a.wen === 1'b1) begin
         wen_a_n++;
         if (bus_a.addr !== exp_addr_a || bus_a.store !== exp_store_a ||
             bus_a.tb_ctrl !== 1'b1 || busy_a !== 1'b1) bad_a_n++;
      end
      if (done_a === 1'b1) done_a_n++;
   end

   always @(negedge clk) begin
      if (bus_b.wen === 1'b1) begin
         wen_b_n++;
         if (bus_b.addr !== exp_addr_b || bus_b.store !== exp_store_b ||
             bus_b.tb_ctrl !== 1'b1 || busy_b !== 1'b1) bad_b_n++;
      end
      if (done_b === 1'b1) done_b_n++;
   end

   logic [15:0] exp_cnt_a, exp_cnt_b;
   logic        exp_err_a;

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press_a(input int k, input logic [15:0] v);
      @(negedge clk);
      sw_a = v;
      key_a[k] = 1'b0;
      idle(12);
      key_a[k] = 1'b1;
      idle(12);
   endtask

   task automatic press_b(input int k, input logic [15:0] v);
      @(negedge clk);
      sw_b = v;
      key_b[k] = 1'b0;
      idle(6);
      key_b[k] = 1'b1;
      idle(6);
   endtask

   task automatic commit_a(input string tag, input logic [15:0] a, input logic h,
                           input logic ok, input word_t st);
      int w0, d0, b0;
      bus_a.halt  = h;
      exp_addr_a  = {16'h0000, a};
      exp_store_a = st;
      w0 = wen_a_n; d0 = done_a_n; b0 = bad_a_n;
      press_a(2, a);
      if (ok) exp_cnt_a = exp_cnt_a + 16'd1;
      else    exp_err_a = 1'b1;
      check({tag, " wen_cycles"}, 32'(wen_a_n - w0), ok ? 32'd2 : 32'd0);
      check({tag, " done_pulses"}, 32'(done_a_n - d0), ok ? 32'd1 : 32'd0);
      check({tag, " bus_values"}, 32'(bad_a_n - b0), 32'd0);
      check({tag, " wr_count"}, 32'(cnt_a), 32'(exp_cnt_a));
      check({tag, " err"}, 32'(err_a), 32'(exp_err_a));
   endtask

   task automatic reset_all();
      @(negedge clk);
      rst = 1'b1;
      key_a = '1;
      key_b = '1;
      idle(2);
      rst = 1'b0;
      exp_cnt_a = '0;
      exp_cnt_b = '0;
      exp_err_a = 1'b0;
   endtask

   typedef struct {
      logic [15:0] lo;
      logic [15:0] hi;
      logic [15:0] a;
      logic        h;
      logic        ok;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int w0, d0, t;
      rst = 1'b1;
      key_a = '1; key_b = '1;
      sw_a = '0; sw_b = '0;
      bus_a.halt = 1'b0; bus_b.halt = 1'b0;
      exp_addr_a = '0; exp_store_a = '0; exp_addr_b = '0; exp_store_b = '0;
      exp_cnt_a = '0; exp_cnt_b = '0; exp_err_a = 1'b0;
      idle(3);
      rst = 1'b0;

      check("reset wen", 32'(bus_a.wen), 32'd0);
      check("reset tb_ctrl", 32'(bus_a.tb_ctrl), 32'd0);
      check("reset busy", 32'(busy_a), 32'd0);
      check("reset done", 32'(done_a), 32'd0);
      check("reset err", 32'(err_a), 32'd0);
      check("reset wr_count", 32'(cnt_a), 32'd0);
      check("reset addr", bus_a.addr, 32'd0);
      check("reset store", bus_a.store, 32'd0);

      vecs[0] = '{lo: 16'hBEEF, hi: 16'hDEAD, a: 16'h0040, h: 1'b1, ok: 1'b1};
      vecs[1] = '{lo: 16'h2222, hi: 16'h1111, a: 16'h0100, h: 1'b1, ok: 1'b1};
      vecs[2] = '{lo: 16'h0000, hi: 16'hFFFF, a: 16'hFFFC, h: 1'b1, ok: 1'b1};
      vecs[3] = '{lo: 16'h3333, hi: 16'h4444, a: 16'h0080, h: 1'b0, ok: 1'b0};
      vecs[4] = '{lo: 16'h5555, hi: 16'h6666, a: 16'h0043, h: 1'b1, ok: 1'b0};

      for (int i = 0; i < 5; i++) begin
         press_a(0, vecs[i].lo);
         press_a(1, vecs[i].hi);
         commit_a($sformatf("vec%0d", i), vecs[i].a, vecs[i].h, vecs[i].ok,
                  {vecs[i].hi, vecs[i].lo});
      end

      // Misaligned address right after reset is rejected on its own.
      reset_all();
      check("rst err cleared", 32'(err_a), 32'd0);
      check("rst wr_count cleared", 32'(cnt_a), 32'd0);
      commit_a("misaligned", 16'h0042, 1'b1, 1'b0, 32'h0);

      // Bounce rejection: toggling faster than the debounce window never latches.
      reset_all();
      press_a(0, 16'h0F0F);
      press_a(1, 16'h7777);
      w0 = wen_a_n; d0 = done_a_n;
      @(negedge clk);
      sw_a = 16'hAAAA;
      for (int i = 0; i < 10; i++) begin
         key_a[0] = ~key_a[0];
         idle(2);
      end
      idle(12);
      check("bounce no wen", 32'(wen_a_n - w0), 32'd0);
      check("bounce no done", 32'(done_a_n - d0), 32'd0);
      commit_a("bounce_released", 16'h0200, 1'b1, 1'b1, 32'h7777_0F0F);
      @(negedge clk);
      sw_a = 16'hAAAA;
      for (int i = 0; i < 9; i++) begin
         if (i == 8) sw_a = 16'h5555;
         key_a[0] = ~key_a[0];
         idle(2);
      end
      idle(12);
      key_a[0] = 1'b1;
      idle(12);
      commit_a("bounce_held", 16'h0204, 1'b1, 1'b1, 32'h7777_5555);

      // Reset while a write is on the bus.
      exp_addr_a = 32'h0000_0300;
      exp_store_a = 32'h7777_5555;
      d0 = done_a_n;
      @(negedge clk);
      sw_a = 16'h0300;
      key_a[2] = 1'b0;
      t = 0;
      while (bus_a.wen !== 1'b1 && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("midwrite wen seen", 32'(bus_a.wen), 32'd1);
      rst = 1'b1;
      key_a[2] = 1'b1;
      idle(2);
      check("midwrite rst wen", 32'(bus_a.wen), 32'd0);
      check("midwrite rst tb_ctrl", 32'(bus_a.tb_ctrl), 32'd0);
      check("midwrite rst busy", 32'(busy_a), 32'd0);
      check("midwrite rst store", bus_a.store, 32'd0);
      rst = 1'b0;
      exp_cnt_a = '0;
      exp_err_a = 1'b0;
      idle(20);
      check("midwrite no done", 32'(done_a_n - d0), 32'd0);
      check("midwrite wr_count", 32'(cnt_a), 32'd0);

      // Counter wrap from a preloaded 16'hFFFF.
      @(negedge clk);
      force dut_a.wr_cnt_q = 16'hFFFF;
      @(negedge clk);
      release dut_a.wr_cnt_q;
      @(negedge clk);
      check("wrap preload", 32'(cnt_a), 32'h0000_FFFF);
      exp_cnt_a = 16'hFFFF;
      commit_a("wrap", 16'h0010, 1'b1, 1'b1, 32'h0);

      // Overlap on the 4-cycle instance: re-commit and lo latch land mid-write.
      bus_b.halt = 1'b1;
      press_b(0, 16'h0A0A);
      press_b(1, 16'h0B0B);
      exp_addr_b = 32'h0000_0080;
      exp_store_b = 32'h0B0B_0A0A;
      w0 = wen_b_n; d0 = done_b_n;
      @(negedge clk);
      sw_b = 16'h0080;
      key_b[2] = 1'b0;
      @(negedge clk);
      key_b[2] = 1'b1;
      @(negedge clk);
      key_b[2] = 1'b0;
      key_b[0] = 1'b0;
      idle(2);
      @(negedge clk);
      sw_b = 16'h1234;
      idle(6);
      key_b[0] = 1'b1;
      key_b[2] = 1'b1;
      idle(10);
      exp_cnt_b = exp_cnt_b + 16'd1;
      check("overlap wen_cycles", 32'(wen_b_n - w0), 32'd4);
      check("overlap done_pulses", 32'(done_b_n - d0), 32'd1);
      check("overlap bus_values", 32'(bad_b_n), 32'd0);
      check("overlap wr_count", 32'(cnt_b), 32'(exp_cnt_b));
      check("overlap err", 32'(err_b), 32'd0);

      exp_addr_b = 32'h0000_0100;
      exp_store_b = 32'h0B0B_1234;
      w0 = wen_b_n; d0 = done_b_n;
      press_b(2, 16'h0100);
      exp_cnt_b = exp_cnt_b + 16'd1;
      check("after_overlap wen_cycles", 32'(wen_b_n - w0), 32'd4);
      check("after_overlap done_pulses", 32'(done_b_n - d0), 32'd1);
      check("after_overlap bus_values", 32'(bad_b_n), 32'd0);
      check("after_overlap wr_count", 32'(cnt_b), 32'(exp_cnt_b));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      failures++;
      $display("FAIL timeout: simulation did not complete, got running expected finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
